ultrasonic_sensor_model: RTL
============================

Name: ultrasonic_sensor_model

Overview:
Synthesizable model of an HC-SR04-style ultrasonic ranging sensor: the responder side of the trigger/echo protocol that the measurement FSM drives. It accepts a trigger pulse, waits a fixed burst time, then drives an echo pulse whose width encodes a programmed target distance. It is used on-board for loop-back bring-up and in simulation as the stimulus source for the distance measurement chain, with no physical sensor attached.

Parameters:
TICKS_PER_US, 50, clk cycles per microsecond.
TRIG_MIN_US, 10, minimum valid trigger high width (us).
BURST_US, 200, delay from valid trigger fall to echo rise (us); models the 8-cycle 40 kHz burst.
US_PER_CM, 58, echo microseconds per centimetre.
MIN_CM, 2, smallest reportable distance; smaller targets are clamped up to it.
MAX_CM, 400, largest reportable distance.
TIMEOUT_US, 38000, echo width when there is no object or the target is out of range.
HOLDOFF_US, 60000, retrigger lockout after echo falls (us).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
trigger  in  1  trigger from measurement FSM; asynchronous to clk
dist_cm  in  9  target distance in cm, unsigned
obj_present  in  1  1 = object in range; 0 = no reflection
echo  out  1  echo pulse to measurement FSM
busy  out  1  high in any state other than IDLE
err_short_trig  out  1  one-cycle pulse when a trigger is rejected as too short

Behaviour:
- Reset (rst=0, asynchronous): echo=0, busy=0, err_short_trig=0, state=IDLE, all counters 0, synchronizer flops 0.
- trigger passes through a 2-flop synchronizer (trig_s). Edge detection runs on trig_s only.
- Shared tick prescaler produces a 1-cycle us_tick every TICKS_PER_US clocks. It is restarted on every state entry, so each phase duration is exact in clk cycles.
- State IDLE: on a trig_s rising edge, go to TRIG_HI and clear the width counter. A trig_s that is already high on entry to IDLE is ignored; a fresh rising edge is required.
- State TRIG_HI: count clk cycles while trig_s=1, saturating at TRIG_MIN_US*TICKS_PER_US. On the trig_s falling edge:
  - if count >= TRIG_MIN_US*TICKS_PER_US: latch dist_cm and obj_present, then go to BURST.
  - otherwise: pulse err_short_trig for 1 cycle and return to IDLE.
- State BURST: lasts exactly BURST_US*TICKS_PER_US cycles. echo is driven high in the first cycle of ECHO.
- Echo width W, computed from the latched values:
  - if obj_present=0 or dist_cm > MAX_CM: W = TIMEOUT_US*TICKS_PER_US.
  - else: W = max(dist_cm, MIN_CM) * US_PER_CM * TICKS_PER_US.
  - Arithmetic is unsigned with a width of at least 32 bits. W is computed during BURST; a multi-cycle shift-add multiplier is allowed provided it finishes within BURST.
- State ECHO: echo=1 for exactly W cycles, then echo=0 and go to HOLDOFF.
- State HOLDOFF: lasts HOLDOFF_US*TICKS_PER_US cycles, then go to IDLE.
- Trigger activity in BURST, ECHO or HOLDOFF is ignored, with no error pulse.
- Changes to dist_cm or obj_present after the latch point do not affect the current pulse.
- busy=1 in TRIG_HI, BURST, ECHO and HOLDOFF.
- Reset asserted mid-operation forces echo low immediately. After release, the block needs a fresh trigger rising edge.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All scenarios use TICKS_PER_US=1 and HOLDOFF_US=1000; other parameters are at their defaults.
1. Nominal: dist_cm=10, obj_present=1, trigger high for 10 cycles -> echo rises 200 cycles after trig_s falls (202 after the raw trigger fall), echo width exactly 580 cycles, busy drops 1000 cycles after echo falls.
2. Short trigger: trigger high for 9 cycles -> err_short_trig pulses for 1 cycle, echo stays 0, busy returns to 0 the cycle after.
3. No object: obj_present=0, dist_cm=50 -> echo width 38000 cycles. Repeat with obj_present=1, dist_cm=401 -> echo width 38000 cycles.
4. Clamp and limit: dist_cm=0 and dist_cm=1 -> echo width 116 cycles each. dist_cm=400 -> echo width 23200 cycles.
5. Lockout and latching:
   - Trigger pulses of 20 cycles during ECHO and during HOLDOFF -> no second echo and no err_short_trig.
   - Trigger held high across the HOLDOFF-to-IDLE transition -> no echo until trigger goes low then high again.
   - Change dist_cm 10 -> 100 during BURST -> echo width stays 580 cycles.
6. Reset mid-echo: drive rst=0 300 cycles into ECHO -> echo and busy go 0 without waiting for a clk edge. After rst=1, a valid trigger with dist_cm=20 -> echo width 1160 cycles.

Source files
------------

// File: rtl/ultrasonic_sensor_model.sv
// Responder side of an HC-SR04-style trigger/echo protocol.
// A valid trigger pulse is followed by a fixed burst delay and then by an echo
// pulse. The echo width encodes the distance that was latched when the trigger fell.
module ultrasonic_sensor_model #(
    parameter int unsigned TICKS_PER_US = 50,
    parameter int unsigned TRIG_MIN_US  = 10,
    parameter int unsigned BURST_US     = 200,
    parameter int unsigned US_PER_CM    = 58,
    parameter int unsigned MIN_CM       = 2,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned TIMEOUT_US   = 38000,
    parameter int unsigned HOLDOFF_US   = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic [8:0] dist_cm,
    input  logic       obj_present,
    output logic       echo,
    output logic       busy,
    output logic       err_short_trig
);

    localparam logic [31:0] TRIG_MIN_CYC = 32'(TRIG_MIN_US * TICKS_PER_US);
    localparam logic [31:0] TIMEOUT_CYC  = 32'(TIMEOUT_US * TICKS_PER_US);
    localparam logic [31:0] CYC_PER_CM   = 32'(US_PER_CM * TICKS_PER_US);
    localparam logic [31:0] BURST_LAST   = 32'(BURST_US - 1);
    localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_US - 1);
    localparam logic [31:0] TICK_LAST    = 32'(TICKS_PER_US - 1);
    // The cycle that detects the trigger fall is the first burst cycle, so the
    // burst starts as if one clock had already elapsed.
    localparam logic [31:0] BURST_PRESC0 = (TICKS_PER_US == 1) ? 32'd0 : 32'd1;
    localparam logic [31:0] BURST_CNT0   = (TICKS_PER_US == 1) ? 32'd1 : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] width_q, width_d;
    logic [8:0]  dist_q, dist_d;
    logic        obj_q, obj_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        trig_s1_q, trig_s_q, trig_prev_q;
    logic        trig_rise;
    logic        us_tick;

    // Echo width in clk cycles. Targets that are absent or too far give the timeout width.
    function automatic logic [31:0] echo_width(input logic [8:0] d, input logic obj);
        logic [31:0] dd;
        dd = {23'd0, d};
        if (!obj || dd > 32'(MAX_CM)) begin
            return TIMEOUT_CYC;
        end
        if (dd < 32'(MIN_CM)) begin
            dd = 32'(MIN_CM);
        end
        return dd * CYC_PER_CM;
    endfunction

    assign trig_rise = trig_s_q & ~trig_prev_q;
    assign us_tick   = (presc_q == TICK_LAST);

    // Next-state logic, phase counting and operand latching
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = us_tick ? 32'd0 : presc_q + 32'd1;
        width_d = width_q;
        dist_d  = dist_q;
        obj_d   = obj_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The cycle that detects the rising edge counts as the first high cycle.
                if (trig_rise) begin
                    state_d = S_TRIG_HI;
                    cnt_d   = 32'd1;
                end
            end
            S_TRIG_HI: begin
                if (trig_s_q) begin
                    if (cnt_q < TRIG_MIN_CYC) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else if (cnt_q >= TRIG_MIN_CYC) begin
                    state_d = S_BURST;
                    dist_d  = dist_cm;
                    obj_d   = obj_present;
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_BURST: begin
                width_d = echo_width(dist_q, obj_q);
                if (us_tick) begin
                    if (cnt_q == BURST_LAST) begin
                        state_d = S_ECHO;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_ECHO: begin
                if (cnt_q == width_q - 32'd1) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HOLDOFF: begin
                if (us_tick) begin
                    if (cnt_q == HOLDOFF_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
        // Restart the prescaler on every state change so phase lengths are exact.
        if (state_d != state_q) begin
            presc_d = 32'd0;
            if (state_d == S_BURST) begin
                presc_d = BURST_PRESC0;
                cnt_d   = BURST_CNT0;
            end
        end
        echo_d = (state_d == S_ECHO);
        busy_d = (state_d != S_IDLE);
    end

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            presc_q     <= 32'd0;
            width_q     <= 32'd0;
            dist_q      <= 9'd0;
            obj_q       <= 1'b0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            trig_s1_q   <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            width_q     <= width_d;
            dist_q      <= dist_d;
            obj_q       <= obj_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            trig_s1_q   <= trigger;
            trig_s_q    <= trig_s1_q;
            trig_prev_q <= trig_s_q;
        end
    end

    assign echo           = echo_q;
    assign busy           = busy_q;
    assign err_short_trig = err_q;

endmodule
